audiodac_nco_wavegen: RTL and testbench

- Parametrised test-tone source for the audio DAC datapath. Phase-accumulator NCO with a quarter-wave sine LUT plus triangle, square and mute modes.
- Adds programmable attenuation and selectable output number format.
- Sits in front of the modulator as the test sample source. Produces one new sample per accepted read strobe from the downstream interpolator/FIFO consumer.

---
 rtl/audiodac_nco_wavegen.sv | 119 +++++++++++
 tb/tb_audiodac_nco_wavegen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/audiodac_nco_wavegen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audiodac_nco_wavegen: NCO test-tone source (sine/triangle/square/mute)     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module audiodac_nco_wavegen #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               data_rd_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic               phase_sync_i,
  input  logic [1:0]         mode_i,
  input  logic [3:0]         atten_i,
  input  logic               fmt_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               valid_o
);

  localparam int N = 1 << LUT_AW;
  localparam logic [DATA_W-1:0] M_POS   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ZERO_OB = {1'b1, {(DATA_W-1){1'b0}}};

  // Quarter-wave table evaluated at elaboration with a fixed-point (2^-30) Taylor series.
  function automatic logic [DATA_W-2:0] lut_entry(input int i);
    longint pih, x, x2, term, acc, m, v;
    pih  = 64'sd1686629713;
    x    = (pih * longint'(2 * i + 1)) / longint'(2 * N);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k <= 10; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
      acc  = acc + term;
    end
    m = (longint'(1) <<< (DATA_W - 1)) - 1;
    v = (m * acc + (longint'(1) <<< 29)) >>> 30;
    return v[DATA_W-2:0];
  endfunction

  logic [DATA_W-2:0] lut [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_lut
    assign lut[gi] = lut_entry(gi);
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;

  logic [1:0]               w_q;
  logic [LUT_AW-1:0]        w_idx;
  logic [DATA_W-2:0]        w_f;
  logic [DATA_W-2:0]        w_lut_val;
  logic [DATA_W-1:0]        w_sin_mag, w_tri_mag;
  logic signed [DATA_W-1:0] w_s, w_a;
  logic [DATA_W-1:0]        w_wave;

  assign w_q       = phase_q[PHASE_W-1:PHASE_W-2];
  assign w_idx     = phase_q[PHASE_W-3 -: LUT_AW];
  assign w_f       = phase_q[PHASE_W-3 -: DATA_W-1];
  // Odd quadrants read the table backwards; N-1-idx is simply ~idx.
  assign w_lut_val = w_q[0] ? lut[~w_idx] : lut[w_idx];
  assign w_sin_mag = {1'b0, w_lut_val};
  assign w_tri_mag = {1'b0, (w_q[0] ? ~w_f : w_f)};

  always_comb begin
    w_s = '0;
    unique case (mode_i)
      2'd0:    w_s = w_q[1] ? -w_sin_mag : w_sin_mag;
      2'd1:    w_s = w_q[1] ? -w_tri_mag : w_tri_mag;
      2'd2:    w_s = w_q[1] ? -M_POS : M_POS;
      default: w_s = '0;
    endcase
  end

  assign w_a    = w_s >>> atten_i;
  assign w_wave = fmt_i ? w_a : {~w_a[DATA_W-1], w_a[DATA_W-2:0]};

  always_comb begin
    phase_d = phase_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (!en_i) begin
      phase_d = '0;
      data_d  = fmt_i ? '0 : ZERO_OB;
    end else begin
      valid_d = data_rd_i;
      if (data_rd_i) begin
        data_d = w_wave;
      end
      if (phase_sync_i) begin
        phase_d = '0;
      end else if (data_rd_i) begin
        phase_d = phase_q + phase_inc_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      phase_q <= '0;
      data_q  <= ZERO_OB;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_audiodac_nco_wavegen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_audiodac_nco_wavegen: scoreboard bench for the NCO test-tone source     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_audiodac_nco_wavegen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        data_rd = 1'b0;
  logic [23:0] phase_inc = '0;
  logic        phase_sync = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  atten = 4'd0;
  logic        fmt = 1'b0;
  logic [15:0] data_o;
  logic        valid_o;

  audiodac_nco_wavegen #(.DATA_W(16), .PHASE_W(24), .LUT_AW(6)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_rd_i(data_rd),
    .phase_inc_i(phase_inc), .phase_sync_i(phase_sync), .mode_i(mode),
    .atten_i(atten), .fmt_i(fmt), .data_o(data_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    bit          chk;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_o=%h with no pending read", data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check(e.name, data_o, e.exp);
      end
    end
  end

  task automatic do_read(input logic [15:0] exp, input bit chk, input string name);
    exp_t e;
    e.exp = exp; e.chk = chk; e.name = name;
    sb.push_back(e);
    data_rd = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    data_rd = 1'b0;
    phase_sync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic restart();
    data_rd = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  initial begin
    int v0;
    logic [15:0] tri_exp [5];
    logic [15:0] sq_exp  [4];
    tri_exp = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001, 16'h0000};
    sq_exp  = '{16'h07FF, 16'h07FF, 16'hF800, 16'hF800};

    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data_o, 16'h8000);
    check("reset_valid", {15'd0, valid_o}, 16'h0000);

    // Sine sweep, one full period plus one.
    rst_n = 1'b1; en = 1'b1; phase_inc = 24'h010000;
    v0 = n_valid;
    for (int i = 1; i <= 257; i++) begin
      case (i)
        1:       do_read(16'h8192, 1'b1, "sine_read1");
        2:       do_read(16'h84B6, 1'b1, "sine_read2");
        129:     do_read(16'h7E6E, 1'b1, "sine_read129");
        257:     do_read(16'h8192, 1'b1, "sine_read257_wrap");
        default: do_read(16'h0000, 1'b0, "");
      endcase
    end
    idle();
    check("sine_valid_count", 16'(n_valid - v0), 16'd257);

    restart();
    mode = 2'd1; fmt = 1'b1; phase_inc = 24'h400000;
    for (int i = 0; i < 5; i++) do_read(tri_exp[i], 1'b1, $sformatf("tri_%0d", i));
    idle();

    restart();
    mode = 2'd2; atten = 4'd4;
    for (int i = 0; i < 4; i++) do_read(sq_exp[i], 1'b1, $sformatf("square_att4_%0d", i));
    idle();
    atten = 4'd15;
    do_read(16'h0000, 1'b1, "square_att15_q0");
    do_read(16'h0000, 1'b1, "square_att15_q1");
    do_read(16'hFFFF, 1'b1, "square_att15_q2");
    idle();

    restart();
    mode = 2'd0; atten = 4'd0; fmt = 1'b0; phase_inc = 24'hFFFFFF;
    do_read(16'h8192, 1'b1, "wrap_read1");
    do_read(16'h7E6E, 1'b1, "wrap_phase_ffffff");
    idle();

    restart();
    phase_inc = 24'h010000;
    do_read(16'h8192, 1'b1, "sync_pre0");
    do_read(16'h84B6, 1'b1, "sync_pre1");
    phase_sync = 1'b1;
    do_read(16'h87D9, 1'b1, "sync_with_read");
    phase_sync = 1'b0;
    do_read(16'h8192, 1'b1, "sync_after");
    idle();

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_data", data_o, 16'h8192);
      check("hold_valid", {15'd0, valid_o}, 16'h0000);
    end

    en = 1'b0;
    data_rd = 1'b1;
    @(posedge clk); #1;
    check("disable_fmt0", data_o, 16'h8000);
    check("disable_valid", {15'd0, valid_o}, 16'h0000);
    fmt = 1'b1;
    @(posedge clk); #1;
    check("disable_fmt1", data_o, 16'h0000);
    fmt = 1'b0; en = 1'b1;
    do_read(16'h8192, 1'b1, "reenable_read");
    do_read(16'h84B6, 1'b1, "reenable_read2");

    // Reset with the read strobe still high.
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_data", data_o, 16'h8000);
    check("midreset_valid", {15'd0, valid_o}, 16'h0000);
    rst_n = 1'b1;
    do_read(16'h8192, 1'b1, "after_midreset");
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
